// File: rtl/conv_window_gen.sv
// conv_window_gen: raster-order pixel stream in, KxK multi-channel windows out.
// Ports:
//   clk, rst (async, active-high)
//   in_valid/in_ready/in_data : one pixel per accept, channel c at [c*DATA_W +: DATA_W]
//   out_valid/out_ready       : one registered output stage
//   out_window                : element (r,c,ch) at [((r*K+c)*CH+ch)*DATA_W +: DATA_W]
//   out_last                  : marks the final window of a frame
module conv_window_gen #(
    parameter int DATA_W = 8,
    parameter int CH     = 1,
    parameter int WIDTH  = 28,
    parameter int HEIGHT = 28,
    parameter int K      = 3,
    parameter int STRIDE = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CH*DATA_W-1:0]        in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [K*K*CH*DATA_W-1:0]    out_window,
    output logic                        out_last
);

    localparam int PW = CH * DATA_W;
    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int RW = (K > 2) ? $clog2(K - 1) : 1;

    // Bottom-right coordinates of the last window that fits the stride grid.
    localparam int XL = (K - 1) + ((WIDTH - K) / STRIDE) * STRIDE;
    localparam int YL = (K - 1) + ((HEIGHT - K) / STRIDE) * STRIDE;

    localparam logic [XW-1:0] X_MAX  = XW'(WIDTH - 1);
    localparam logic [XW-1:0] X_K    = XW'(K - 1);
    localparam logic [XW-1:0] X_LAST = XW'(XL);
    localparam logic [YW-1:0] Y_MAX  = YW'(HEIGHT - 1);
    localparam logic [YW-1:0] Y_K    = YW'(K - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(YL);
    localparam logic [SW-1:0] S_MAX  = SW'(STRIDE - 1);
    localparam logic [RW-1:0] R_MAX  = RW'(K - 2);
    localparam logic [RW:0]   R_CNT  = (RW+1)'(K - 1);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [SW-1:0] px;
    logic [SW-1:0] py;
    // Slot holding the oldest stored row; advances once per line.
    logic [RW-1:0] head;

    logic [PW-1:0] lb [K-1][WIDTH];
    logic [PW-1:0] win [K][K];
    logic [PW-1:0] win_nxt [K][K];
    logic [PW-1:0] col [K];
    logic [RW:0]   rsum [K-1];
    logic [K*K*PW-1:0] win_flat;

    logic accept;
    logic emit;
    logic last;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // px/py are the stride phases of the current column/row; zero on grid points.
    assign emit = (x >= X_K) && (y >= Y_K) && (px == '0) && (py == '0);
    assign last = emit && (x == X_LAST) && (y == Y_LAST);

    always_comb begin
        win_flat = '0;
        // Column x, oldest row first, new pixel at the bottom.
        for (int r = 0; r < K - 1; r++) begin
            rsum[r] = {1'b0, head} + (RW+1)'(r);
            if (rsum[r] >= R_CNT)
                rsum[r] = rsum[r] - R_CNT;
            col[r] = lb[rsum[r][RW-1:0]][x];
        end
        col[K-1] = in_data;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++)
                win_nxt[r][c] = win[r][c+1];
            win_nxt[r][K-1] = col[r];
        end
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                win_flat[(r*K+c)*PW +: PW] = win_nxt[r][c];
    end

    // Line storage is deliberately not reset; unfilled rows never reach
    // an emitted window.
    always_ff @(posedge clk) begin
        if (accept)
            lb[head][x] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x          <= '0;
            y          <= '0;
            px         <= '0;
            py         <= '0;
            head       <= '0;
            out_valid  <= 1'b0;
            out_window <= '0;
            out_last   <= 1'b0;
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    win[r][c] <= '0;
        end else begin
            if (accept) begin
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        win[r][c] <= win_nxt[r][c];

                if (x == X_MAX) begin
                    x    <= '0;
                    px   <= '0;
                    head <= (head == R_MAX) ? '0 : head + 1'b1;
                    if (y == Y_MAX) begin
                        y  <= '0;
                        py <= '0;
                    end else begin
                        y <= y + 1'b1;
                        if (y >= Y_K)
                            py <= (py == S_MAX) ? '0 : py + 1'b1;
                        else
                            py <= '0;
                    end
                end else begin
                    x <= x + 1'b1;
                    if (x >= X_K)
                        px <= (px == S_MAX) ? '0 : px + 1'b1;
                    else
                        px <= '0;
                end
            end

            if (accept && emit) begin
                out_valid  <= 1'b1;
                out_window <= win_flat;
                out_last   <= last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: directed checks of conv_window_gen on a 5x5 image,
// stride 1 and 2, one and two channels, with stall, gaps and mid-frame reset.
module tb_conv_window_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_data;

    logic         a_in_ready, a_out_valid, a_out_last;
    logic [71:0]  a_out_window;
    logic         b_in_ready, b_out_valid, b_out_last;
    logic [71:0]  b_out_window;
    logic         c_in_ready, c_out_valid, c_out_last;
    logic [143:0] c_out_window;

    conv_window_gen #(.DATA_W(8), .CH(1), .WIDTH(5), .HEIGHT(5), .K(3), .STRIDE(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data[7:0]), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_window(a_out_window), .out_last(a_out_last)
    );

    conv_window_gen #(.DATA_W(8), .CH(1), .WIDTH(5), .HEIGHT(5), .K(3), .STRIDE(2)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data[7:0]), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_window(b_out_window), .out_last(b_out_last)
    );

    conv_window_gen #(.DATA_W(8), .CH(2), .WIDTH(5), .HEIGHT(5), .K(3), .STRIDE(1)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_window(c_out_window), .out_last(c_out_last)
    );

    int total = 0;
    int bad   = 0;

    logic [71:0]  qa_w [$];
    logic [71:0]  qb_w [$];
    logic [143:0] qc_w [$];
    bit           qa_l [$];
    bit           qb_l [$];
    bit           qc_l [$];

    always @(negedge clk) begin
        if (a_out_valid && out_ready) begin
            qa_w.push_back(a_out_window);
            qa_l.push_back(a_out_last);
        end
        if (b_out_valid && out_ready) begin
            qb_w.push_back(b_out_window);
            qb_l.push_back(b_out_last);
        end
        if (c_out_valid && out_ready) begin
            qc_w.push_back(c_out_window);
            qc_l.push_back(c_out_last);
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // 5x5 image, pixel value y*5+x; window with bottom-right (bx,by).
    function automatic logic [71:0] exp1(input int bx, input int by);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[(r*3+c)*8 +: 8] = 8'((by - 2 + r) * 5 + bx - 2 + c);
        return w;
    endfunction

    function automatic logic [143:0] exp2(input int bx, input int by);
        logic [143:0] w;
        int v;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                v = (by - 2 + r) * 5 + bx - 2 + c;
                w[((r*3+c)*2)*8 +: 8]     = 8'(v);
                w[((r*3+c)*2+1)*8 +: 8]   = 8'(v + 100);
            end
        return w;
    endfunction

    task automatic clear_q();
        qa_w.delete(); qa_l.delete();
        qb_w.delete(); qb_l.delete();
        qc_w.delete(); qc_l.delete();
    endtask

    task automatic verify(input int nf);
        check("count_s1", 256'(qa_w.size()), 256'(9 * nf));
        check("count_s2", 256'(qb_w.size()), 256'(4 * nf));
        check("count_ch2", 256'(qc_w.size()), 256'(9 * nf));
        for (int i = 0; i < qa_w.size() && i < 9 * nf; i++) begin
            int k;
            k = i % 9;
            check("win_s1", 256'(qa_w[i]), 256'(exp1(2 + k % 3, 2 + k / 3)));
            check("last_s1", 256'(qa_l[i]), 256'(k == 8));
        end
        for (int i = 0; i < qb_w.size() && i < 4 * nf; i++) begin
            int k;
            k = i % 4;
            check("win_s2", 256'(qb_w[i]), 256'(exp1(2 + 2 * (k % 2), 2 + 2 * (k / 2))));
            check("last_s2", 256'(qb_l[i]), 256'(k == 3));
        end
        for (int i = 0; i < qc_w.size() && i < 9 * nf; i++) begin
            int k;
            k = i % 9;
            check("win_ch2", 256'(qc_w[i]), 256'(exp2(2 + k % 3, 2 + k / 3)));
            check("last_ch2", 256'(qc_l[i]), 256'(k == 8));
        end
        clear_q();
    endtask

    // Feeds n pixels starting at raster index start. With stall set, the
    // consumer stops for 3 cycles right after the first pixel of the call.
    task automatic feed(input int start, input int n, input bit gaps, input bit stall);
        for (int i = 0; i < n; i++) begin
            int p;
            int wcnt;
            bit acc;
            p = (start + i) % 25;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_data  = {8'(p + 100), 8'(p)};
            acc  = 1'b0;
            wcnt = 0;
            while (!acc && wcnt < 50) begin
                @(negedge clk);
                acc = a_in_ready;
                @(posedge clk);
                #1;
                wcnt++;
            end
            if (!acc)
                check("feed_timeout", 256'(0), 256'(1));
            if (stall && i == 0) begin
                int q;
                q = (p + 1) % 25;
                in_data   = {8'(q + 100), 8'(q)};
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_valid", 256'(a_out_valid), 256'(1));
                    check("stall_ready", 256'(a_in_ready), 256'(0));
                    check("stall_win", 256'(a_out_window), 256'(exp1(2, 2)));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 256'(a_out_valid), 256'(0));
        check("rst_win", 256'(a_out_window), 256'(0));
        check("rst_last", 256'(a_out_last), 256'(0));
        check("rst_ready", 256'(a_in_ready), 256'(1));
        check("rst_win_ch2", 256'(c_out_window), 256'(0));
        check("rst_valid_s2", 256'(b_out_valid), 256'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Frame with a consumer stall on the first window.
        feed(0, 12, 1'b0, 1'b0);
        check("pre12_s1", 256'(qa_w.size()), 256'(0));
        check("pre12_s2", 256'(qb_w.size()), 256'(0));
        feed(12, 13, 1'b0, 1'b1);
        drain();
        verify(1);

        // Two back-to-back frames with random input gaps.
        feed(0, 50, 1'b1, 1'b0);
        drain();
        verify(2);

        // Reset after 13 accepts, then a clean frame.
        feed(0, 13, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", 256'(a_out_valid), 256'(0));
        check("midrst_last", 256'(a_out_last), 256'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_q();
        feed(0, 12, 1'b0, 1'b0);
        check("rst_pre12_s1", 256'(qa_w.size()), 256'(0));
        check("rst_pre12_ch2", 256'(qc_w.size()), 256'(0));
        feed(12, 13, 1'b0, 1'b0);
        drain();
        verify(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Parametrised sliding-window generator. It streams raster-order pixels from the input image or from a previous layer, and emits KxK multi-channel windows for the convolution MAC stage. It generalises the fixed 3x3, 8-bit, single-channel conv1 buffer to:
- configurable kernel size, data width, channel count and stride;
- full valid/ready backpressure on both sides;
- an end-of-frame marker.

## Interface
Parameters:
- DATA_W, 8, bits per channel sample
- CH, 1, channels per pixel (packed on one beat)
- WIDTH, 28, image width in pixels (>= K)
- HEIGHT, 28, image height in pixels (>= K)
- K, 3, kernel size (2..7)
- STRIDE, 1, window stride in both axes (1..K)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept a pixel
- in_data  in  CH*DATA_W  pixel; channel c at bits [c*DATA_W +: DATA_W]
- out_valid  out  1  window valid
- out_ready  in  1  consumer accepts window
- out_window  out  K*K*CH*DATA_W  window; element (r,c,ch) at bits [((r*K+c)*CH+ch)*DATA_W +: DATA_W]
  - r=0 is the oldest (top) row; c=0 is the leftmost column
- out_last  out  1  high with the final window of a frame

## Operation
- Accept occurs when in_valid && in_ready. Only accepts advance x/y counters, line buffers and window registers.
- in_ready = !out_valid || out_ready. This is combinational, and a single output register stage is used.
- Counters:
  - x runs 0..WIDTH-1 and y runs 0..HEIGHT-1.
  - At x=WIDTH-1, x wraps to 0 and y increments.
  - At (WIDTH-1, HEIGHT-1), both wrap to 0, so the next accept is pixel (0,0) of a new frame with no idle cycle.
- Line storage:
  - K-1 rows of WIDTH x CH x DATA_W, with circular row index (no modulo operator; compare-and-wrap).
  - Each row of the current column shifts up and the new pixel forms the bottom row.
- Window register:
  - K x K x CH.
  - On accept, columns shift left and column K-1 is loaded with the K vertically aligned samples of column x.
- Emission condition on an accept of pixel (x,y):
  - x >= K-1 and y >= K-1;
  - (x-(K-1)) % STRIDE == 0 and (y-(K-1)) % STRIDE == 0.
  - Implement the stride test with phase counters, not division.
- Emitted window:
  - Rows y-K+1..y and columns x-K+1..x, inclusive of the accepted pixel.
  - Window columns that straddle a row wrap are never emitted.
- out_last = 1 on the emitted window whose bottom-right is the last qualifying (x,y) of the frame.
- Windows per frame: ((WIDTH-K)/STRIDE+1)*((HEIGHT-K)/STRIDE+1), using floor division.
- Line-buffer contents are not reset. Because of the emission condition, stale data is never emitted.

## Timing
- Reset values: out_valid=0, out_window=0, out_last=0, x=y=0, stride phases=0, window regs=0. in_ready=1 during and after reset.
- Latency: the window is on out_window with out_valid=1 in the cycle after the accepting edge of its bottom-right pixel.
- Handshake:
  - While out_valid && !out_ready, out_window and out_last hold stable and in_ready=0.
  - On out_valid && out_ready, the window is consumed. In the same cycle a new pixel may be accepted, giving full throughput of 1 pixel/cycle.
  - If an accept does not produce a window and the previous one was consumed, out_valid drops to 0.
- in_valid low produces no state change. A pending out_valid remains until consumed.
- Simultaneous consume plus an emitting accept: out_valid stays 1 with the new window.
- Reset mid-frame: counters return to 0 immediately. Any pending window is discarded, and the next accepted pixel is (0,0).
- Widths: x needs $clog2(WIDTH) bits and y needs $clog2(HEIGHT) bits, minimum 1. No arithmetic is performed on sample data.

## Test plan
- WIDTH=HEIGHT=5, K=3, STRIDE=1, CH=1, pixel=y*5+x, out_ready=1 -> 9 windows.
  - First window appears 1 cycle after accepting pixel 12, with elements {0,1,2,5,6,7,10,11,12}.
  - The 9th window has bottom-right 24 and out_last=1.
- Same image with STRIDE=2 -> exactly 4 windows, bottom-right pixels 12, 14, 22, 24; out_last only on 24.
- STRIDE=1, drop out_ready for 3 cycles when the first window appears -> out_window is stable at {0..12 set}, in_ready=0 and no pixel is lost. All 9 windows arrive in order.
- CH=2, DATA_W=8, channel1=channel0+100 -> every window has the ch1 element = ch0 element + 100 at the specified bit offsets.
- Two back-to-back frames with random in_valid gaps -> frame 2 yields the same 9 windows as frame 1 with no stale rows.
- Assert rst after 13 accepts (frame 1) and restart the frame -> no window is emitted until a fresh pixel 12 is accepted. The output sequence matches a clean run.
